mesh_frame_loader: RTL
======================

MESH_FRAME_LOADER -- requirements
Module: mesh_frame_loader

Interface
REQ-001 SHALL have parameter N, default 4, mesh dimension (mesh is N x N, N >= 2).
REQ-002 SHALL have parameter WIDTH, default 8, element width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream element valid.
REQ-006 SHALL have port in_ready  output  1  loader accepts an element this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  element value, unsigned.
REQ-008 SHALL have port in_last  input  1  upstream marks final element of a frame.
REQ-009 SHALL have port matrix_out  output  N*N*WIDTH  assembled frame, element (r,c) at bits [(r*N+c)*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  output  1  matrix_out holds a complete frame.
REQ-011 SHALL have port out_ready  input  1  downstream sorter takes the frame.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a framing error.
REQ-013 SHALL have port frame_count  output  16  count of frames handed downstream.

Function
REQ-014 SHALL implement a two-state FSM: FILL and HOLD.
REQ-015 SHALL drive in_ready = 1 in FILL and 0 in HOLD, decoded from registered state only, with no combinational path from any input.
REQ-016 SHALL accept an element on a cycle with in_valid && in_ready, and write in_data into slot idx, where idx is a registered counter 0..N*N-1 in row-major order.
REQ-017 SHALL increment idx on each accept while in FILL.
REQ-018 SHALL move to HOLD on accepting idx == N*N-1, with out_valid = 1 in the next cycle (latency 1).
REQ-019 SHALL keep matrix_out and out_valid stable in HOLD until out_valid && out_ready.
REQ-020 SHALL, on out_valid && out_ready: return to FILL next cycle, set idx = 0, and increment frame_count modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-021 SHALL treat an accepted in_last with idx < N*N-1 as an early end: discard the partial frame (idx = 0, stay in FILL), pulse frame_err for one cycle, and leave frame_count unchanged.
REQ-022 SHALL treat an accept of idx == N*N-1 with in_last = 0 as a missing last: still complete the frame into HOLD, and pulse frame_err for one cycle.
REQ-023 SHALL give no meaning to slot contents of matrix_out while out_valid = 0; stale slots from a prior frame are permitted.
REQ-024 SHALL ignore in_valid, in_data and in_last while in HOLD.
REQ-025 SHALL ignore out_ready while in FILL.
REQ-026 SHALL, on the cycle the frame leaves (out handshake), not accept input; the first accept of the next frame occurs at the earliest one cycle later, so the throughput ceiling is one frame per N*N+1 cycles.

Reset
REQ-027 SHALL, on reset assertion, immediately force: state FILL, idx 0, matrix_out all zero, out_valid 0, frame_err 0, frame_count 0.
REQ-028 SHALL have in_ready = 1 during and directly after reset.
REQ-029 SHALL abandon any partially filled or held frame on reset mid-operation, with no frame_count change and no frame_err.

Structure
REQ-030 SHALL take shared constants (default N, WIDTH, FILL/HOLD state encodings) from the sorter project's shared mesh_sort_pkg, which the downstream sorter also uses.
REQ-031 SHALL be a single module; the index counter and FSM are inline, and no sub-module is instantiated.

Verification
REQ-032 SHALL verify a nominal frame: N=4; 16 elements 16..1 with in_last on the 16th and out_ready = 1 -> out_valid exactly 1 cycle after the 16th accept, slot 0 = 16, slot 15 = 1, frame_count 0 -> 1, frame_err never set.
REQ-033 SHALL verify backpressure: out_ready held 0 for 10 cycles while the source keeps in_valid = 1 -> in_ready stays 0, matrix_out stays unchanged, no extra accepts, frame passes on the first out_ready = 1.
REQ-034 SHALL verify an early last: in_last on the 5th element -> frame_err pulses exactly once, idx resets, the next 16 elements form a correct frame, frame_count increments by 1 only.
REQ-035 SHALL verify a missing last: 16 elements with in_last = 0 -> frame completes to out_valid = 1 and frame_err pulses once, on the 16th-accept cycle + 1.
REQ-036 SHALL verify reset mid-fill: reset asserted after 9 accepts -> all outputs zero, in_ready = 1; afterwards a fresh 16-element frame completes correctly.
REQ-037 SHALL verify wrap: frame_count preloaded by driving 65535 frames (or by a forced start value) -> next handshake gives frame_count = 0.

Source files
------------

// File: rtl/mesh_sort_pkg.sv
// Constants and state encodings shared by the mesh frame loader and the
// downstream mesh sorter.
package mesh_sort_pkg;

    localparam int MESH_N        = 4;
    localparam int MESH_WIDTH    = 8;
    localparam int FRAME_COUNT_W = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_e;

endpackage

// File: rtl/mesh_frame_loader_if.sv
// Element stream in, assembled frame out: the bus between source, loader and sorter.
// The slave modport is the loader's view; master is the surrounding environment.
interface mesh_frame_loader_if import mesh_sort_pkg::*; #(
    parameter int N     = MESH_N,
    parameter int WIDTH = MESH_WIDTH
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic                     in_last;
    logic [N*N*WIDTH-1:0]     matrix_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     frame_err;
    logic [FRAME_COUNT_W-1:0] frame_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, matrix_out, out_valid, frame_err, frame_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, matrix_out, out_valid, frame_err, frame_count
    );

endinterface

// File: rtl/mesh_frame_loader.sv
// Collects N*N streamed elements row-major into one frame, holds it until the
// sorter takes it, and flags frames whose in_last marker is misplaced.
module mesh_frame_loader import mesh_sort_pkg::*; #(
    parameter int N     = MESH_N,
    parameter int WIDTH = MESH_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    mesh_frame_loader_if.slave  bus
);

    localparam int SLOTS = N * N;
    localparam int IDX_W = $clog2(SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    loader_state_e            state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [SLOTS*WIDTH-1:0]   matrix_q, matrix_d;
    logic                     frame_err_q, frame_err_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
    logic                     accept;

    // Ready depends only on registered state, so there is no input-to-ready path.
    assign bus.in_ready    = (state_q == FILL);
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.matrix_out  = matrix_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_count = frame_count_q;
    assign accept          = bus.in_valid && (state_q == FILL);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        matrix_d      = matrix_q;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    for (int s = 0; s < SLOTS; s++) begin
                        if (idx_q == IDX_W'(s)) begin
                            matrix_d[s*WIDTH +: WIDTH] = bus.in_data;
                        end
                    end
                    // A missing last still completes the frame; an early last drops it.
                    if (idx_q == LAST_IDX) begin
                        state_d     = HOLD;
                        idx_d       = '0;
                        frame_err_d = !bus.in_last;
                    end else if (bus.in_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d       = FILL;
                    idx_d         = '0;
                    frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            idx_q         <= '0;
            matrix_q      <= '0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            matrix_q      <= matrix_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
